rob_ctrl: RTL and testbench

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/rob_ctrl.sv | 137 +++++++++++++
 tb/tb_rob_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// Reorder-buffer row controller: allocates rows at the tail, retires rows at the head,
// rolls the tail back on a branch kill and scrubs every row after an exception flush.
module rob_ctrl #(
    parameter int WIDTH_BANK = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_dis_req,
    output logic                  o_dis_ready,
    output logic                  o_dis_we,
    output logic [WIDTH_BANK-1:0] o_dis_tag,
    input  logic                  i_com_ready,
    output logic                  o_com_en,
    output logic [WIDTH_BANK-1:0] o_head_tag,
    input  logic                  i_kill_en,
    input  logic [WIDTH_BANK-1:0] i_kill_tag,
    input  logic                  i_flush,
    output logic                  o_clr_we,
    output logic [WIDTH_BANK-1:0] o_clr_tag,
    output logic [WIDTH_BANK:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_busy
);

    localparam int SIZE = 2 ** WIDTH_BANK;
    localparam int PW   = WIDTH_BANK + 1;

    localparam logic [PW-1:0]         SIZE_P   = PW'(SIZE);
    localparam logic [PW-1:0]         ONE_P    = PW'(1);
    localparam logic [WIDTH_BANK-1:0] ONE_R    = WIDTH_BANK'(1);
    localparam logic [WIDTH_BANK-1:0] LAST_ROW = WIDTH_BANK'(SIZE - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        KILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Pointers carry an extra wrap bit so full and empty stay distinguishable.
    logic [PW-1:0]         head, tail;
    logic [PW-1:0]         head_nxt, tail_nxt;
    logic [PW-1:0]         count;
    logic [WIDTH_BANK-1:0] scrub_cnt, scrub_nxt;
    logic [WIDTH_BANK-1:0] kill_ofs;
    logic                  kill_hit;
    logic                  in_run;

    assign in_run  = (state == RUN);
    assign count   = tail - head;
    assign o_count = count;
    assign o_full  = (count == SIZE_P);
    assign o_empty = (count == '0);

    assign o_dis_ready = in_run & ~o_full & ~i_kill_en & ~i_flush;
    assign o_dis_we    = i_dis_req & o_dis_ready;
    assign o_com_en    = in_run & ~o_empty & i_com_ready & ~i_flush;

    assign o_dis_tag  = tail[WIDTH_BANK-1:0];
    assign o_head_tag = head[WIDTH_BANK-1:0];

    // Distance of the killed row from the head; it survives only if it lies inside the occupied window.
    assign kill_ofs = i_kill_tag - head[WIDTH_BANK-1:0];
    assign kill_hit = in_run & i_kill_en & ~o_empty & ({1'b0, kill_ofs} < count);

    assign o_busy    = ~in_run;
    assign o_clr_we  = (state == FLUSH);
    assign o_clr_tag = o_clr_we ? scrub_cnt : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= RUN;
            head      <= '0;
            tail      <= '0;
            scrub_cnt <= '0;
        end else begin
            state     <= state_nxt;
            head      <= head_nxt;
            tail      <= tail_nxt;
            scrub_cnt <= scrub_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        scrub_nxt = scrub_cnt;

        case (state)
            RUN: begin
                if (i_flush) begin
                    state_nxt = FLUSH;
                    scrub_nxt = '0;
                end else begin
                    if (o_com_en) begin
                        head_nxt = head + ONE_P;
                    end
                    // The new tail is measured from the head as it was before any same-cycle commit.
                    if (kill_hit) begin
                        tail_nxt  = head + PW'(kill_ofs) + ONE_P;
                        state_nxt = KILL;
                    end else if (o_dis_we) begin
                        tail_nxt = tail + ONE_P;
                    end
                end
            end

            KILL: begin
                if (i_flush) begin
                    state_nxt = FLUSH;
                    scrub_nxt = '0;
                end else begin
                    state_nxt = RUN;
                end
            end

            FLUSH: begin
                if (scrub_cnt == LAST_ROW) begin
                    state_nxt = RUN;
                    head_nxt  = '0;
                    tail_nxt  = '0;
                    scrub_nxt = '0;
                end else begin
                    scrub_nxt = scrub_cnt + ONE_R;
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Randomised and directed stimulus for rob_ctrl; a queue-based ROB model predicts every
// cycle's outputs and a negedge monitor compares them against the DUT.
module tb_rob_ctrl;

    localparam int WB   = 3;
    localparam int SIZE = 2 ** WB;

    logic          clk;
    logic          i_rst;
    logic          i_dis_req;
    logic          o_dis_ready;
    logic          o_dis_we;
    logic [WB-1:0] o_dis_tag;
    logic          i_com_ready;
    logic          o_com_en;
    logic [WB-1:0] o_head_tag;
    logic          i_kill_en;
    logic [WB-1:0] i_kill_tag;
    logic          i_flush;
    logic          o_clr_we;
    logic [WB-1:0] o_clr_tag;
    logic [WB:0]   o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_busy;

    rob_ctrl #(.WIDTH_BANK(WB)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_dis_req   (i_dis_req),
        .o_dis_ready (o_dis_ready),
        .o_dis_we    (o_dis_we),
        .o_dis_tag   (o_dis_tag),
        .i_com_ready (i_com_ready),
        .o_com_en    (o_com_en),
        .o_head_tag  (o_head_tag),
        .i_kill_en   (i_kill_en),
        .i_kill_tag  (i_kill_tag),
        .i_flush     (i_flush),
        .o_clr_we    (o_clr_we),
        .o_clr_tag   (o_clr_tag),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_RUN, M_KILL, M_FLUSH} mode_t;

    typedef struct {
        int cyc;
        int dis_ready;
        int dis_we;
        int dis_tag;
        int com_en;
        int head_tag;
        int clr_we;
        int clr_tag;
        int count;
        int full;
        int empty;
        int busy;
    } exp_t;

    exp_t sb_q[$];

    // ROB model: head row index plus number of occupied rows.
    mode_t m_mode  = M_RUN;
    int    m_head  = 0;
    int    m_count = 0;
    int    m_scrub = 0;
    int    cyc     = 0;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input int at_cyc, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", name, at_cyc, actual, expected);
        end
    endtask

    // One clock of stimulus: predict this cycle's outputs, queue them, then advance the model.
    task automatic applyStimulus(input bit req, input bit cr, input bit kill, input int ktag,
                                 input bit flush, input bit rst);
        exp_t e;
        bit   run, full, empty, com, dis;
        int   ofs;
        @(posedge clk);
        #1;
        cyc++;
        i_rst       = rst;
        i_dis_req   = req;
        i_com_ready = cr;
        i_kill_en   = kill;
        i_kill_tag  = WB'(ktag);
        i_flush     = flush;

        if (rst) begin
            m_mode  = M_RUN;
            m_head  = 0;
            m_count = 0;
            m_scrub = 0;
        end

        run   = (m_mode == M_RUN);
        full  = (m_count == SIZE);
        empty = (m_count == 0);
        dis   = req && run && !full && !kill && !flush;
        com   = run && !empty && cr && !flush;

        e.cyc       = cyc;
        e.dis_ready = int'(run && !full && !kill && !flush);
        e.dis_we    = int'(dis);
        e.dis_tag   = (m_head + m_count) % SIZE;
        e.com_en    = int'(com);
        e.head_tag  = m_head;
        e.clr_we    = int'(m_mode == M_FLUSH);
        e.clr_tag   = (m_mode == M_FLUSH) ? m_scrub : 0;
        e.count     = m_count;
        e.full      = int'(full);
        e.empty     = int'(empty);
        e.busy      = int'(!run);
        sb_q.push_back(e);

        if (!rst) begin
            if (flush && m_mode != M_FLUSH) begin
                m_mode  = M_FLUSH;
                m_scrub = 0;
            end else if (m_mode == M_FLUSH) begin
                if (m_scrub == SIZE - 1) begin
                    m_mode  = M_RUN;
                    m_head  = 0;
                    m_count = 0;
                    m_scrub = 0;
                end else begin
                    m_scrub++;
                end
            end else if (m_mode == M_KILL) begin
                m_mode = M_RUN;
            end else begin
                ofs = ((ktag - m_head) % SIZE + SIZE) % SIZE;
                if (kill && !empty && ofs < m_count) begin
                    m_count = ofs + 1;
                    m_mode  = M_KILL;
                end else if (dis) begin
                    m_count++;
                end
                if (com) begin
                    m_head = (m_head + 1) % SIZE;
                    m_count--;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    exp_t mon_e;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("dis_ready", mon_e.cyc, int'(o_dis_ready), mon_e.dis_ready);
            checkOutput("dis_we",    mon_e.cyc, int'(o_dis_we),    mon_e.dis_we);
            checkOutput("dis_tag",   mon_e.cyc, int'(o_dis_tag),   mon_e.dis_tag);
            checkOutput("com_en",    mon_e.cyc, int'(o_com_en),    mon_e.com_en);
            checkOutput("head_tag",  mon_e.cyc, int'(o_head_tag),  mon_e.head_tag);
            checkOutput("clr_we",    mon_e.cyc, int'(o_clr_we),    mon_e.clr_we);
            checkOutput("clr_tag",   mon_e.cyc, int'(o_clr_tag),   mon_e.clr_tag);
            checkOutput("count",     mon_e.cyc, int'(o_count),     mon_e.count);
            checkOutput("full",      mon_e.cyc, int'(o_full),      mon_e.full);
            checkOutput("empty",     mon_e.cyc, int'(o_empty),     mon_e.empty);
            checkOutput("busy",      mon_e.cyc, int'(o_busy),      mon_e.busy);
        end
    end

    initial begin
        i_rst       = 1'b1;
        i_dis_req   = 1'b0;
        i_com_ready = 1'b0;
        i_kill_en   = 1'b0;
        i_kill_tag  = '0;
        i_flush     = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset_empty", cyc, int'(o_empty), 1);
        checkOutput("reset_ready", cyc, int'(o_dis_ready), 1);

        // Fill from empty, then one request too many.
        for (int i = 0; i < SIZE; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fill_full",  cyc, int'(o_full), 1);
        checkOutput("fill_count", cyc, int'(o_count), 8);
        checkOutput("fill_ready", cyc, int'(o_dis_ready), 0);

        // Full with commit and dispatch together: only the commit goes through.
        applyStimulus(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("full_com_en", cyc, int'(o_com_en), 1);
        checkOutput("full_dis_we", cyc, int'(o_dis_we), 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("after_com_count", cyc, int'(o_count), 7);
        checkOutput("after_com_dis_we", cyc, int'(o_dis_we), 1);

        // Build head=6, tail=2 (count 4).
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < SIZE; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 1, 3, 0, 0);
        idle(1);
        @(negedge clk);
        checkOutput("kill_out_count", cyc, int'(o_count), 4);
        checkOutput("kill_out_busy",  cyc, int'(o_busy), 0);

        applyStimulus(0, 0, 1, 7, 0, 0);
        idle(1);
        @(negedge clk);
        checkOutput("kill_wrap_count", cyc, int'(o_count), 2);
        checkOutput("kill_wrap_busy",  cyc, int'(o_busy), 1);
        checkOutput("kill_wrap_tail",  cyc, int'(o_dis_tag), 0);
        idle(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("kill_next_we",  cyc, int'(o_dis_we), 1);
        checkOutput("kill_next_tag", cyc, int'(o_dis_tag), 0);

        // Count 5, then flush racing a kill, a dispatch and a commit.
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 7, 1, 0);
        idle(SIZE);
        idle(1);
        @(negedge clk);
        checkOutput("flush_count", cyc, int'(o_count), 0);
        checkOutput("flush_head",  cyc, int'(o_head_tag), 0);
        checkOutput("flush_ready", cyc, int'(o_dis_ready), 1);

        // Reset in the 4th scrub cycle aborts the scrub at once.
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(3);
        applyStimulus(0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("abort_clr_we", cyc, int'(o_clr_we), 0);
        checkOutput("abort_busy",   cyc, int'(o_busy), 0);
        @(negedge clk);
        checkOutput("abort_empty",  cyc, int'(o_empty), 1);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 2) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 5) == 0,
                          int'($urandom_range(0, SIZE - 1)),
                          $urandom_range(0, 49) == 0,
                          $urandom_range(0, 299) == 0);
        end
        idle(1);

        @(negedge clk);
        @(negedge clk);
        checkOutput("sb_drained", cyc, sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
